fb_blit_sequencer: RTL and testbench

Per-frame write sequencer for the 640x480 4-bit-index framebuffer write port. On each frame-start pulse it erases the sprite rectangle drawn in the previous frame with the background index, then copies the sprite from a sprite-index ROM to its new position, one pixel per cycle. It is the sole driver of the framebuffer's `we`, `write_x`, `write_y` and `write_index`. It sits between the VGA timing and sprite-position logic and the framebuffer.

---
 rtl/fb_blit_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fb_blit_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_blit_sequencer.sv
// Per-frame framebuffer write sequencer: erases the previous sprite rectangle, then draws the new one.
// Define BLIT_TRANSPARENCY_EN to suppress DRAW writes of pixels whose ROM index equals TRANSP_IDX.
module fb_blit_sequencer #(
    parameter int unsigned SPR_W      = 32,
    parameter int unsigned SPR_H      = 32,
    parameter logic [3:0]  TRANSP_IDX = 4'h0,
    localparam int unsigned N         = SPR_W * SPR_H,
    localparam int unsigned AW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame_start,
    input  logic [9:0]    sprite_x,
    input  logic [8:0]    sprite_y,
    input  logic [3:0]    bg_index,
    output logic [AW-1:0] sprite_addr,
    input  logic [3:0]    sprite_index,
    output logic          we,
    output logic [9:0]    write_x,
    output logic [8:0]    write_y,
    output logic [3:0]    write_index,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

`ifdef BLIT_TRANSPARENCY_EN
    localparam bit TranspEn = 1'b1;
`else
    localparam bit TranspEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StErase, StDraw, StDrain} state_e;

    state_e      state_q, state_d;
    logic [5:0]  col_q, col_d, row_q, row_d;
    logic        drain_q, drain_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic        prev_valid_q, prev_valid_d;
    logic [9:0]  prev_x_q, prev_x_d, new_x_q, new_x_d;
    logic [8:0]  prev_y_q, prev_y_d, new_y_q, new_y_d;
    logic [3:0]  bg_q, bg_d;
    // Stage 1: pixel coordinates, aligned with the ROM read.
    logic        s1_valid_q, s1_valid_d, s1_draw_q, s1_draw_d, s1_in_q, s1_in_d;
    logic [9:0]  s1_x_q, s1_x_d;
    logic [8:0]  s1_y_q, s1_y_d;
    // Stage 2: registered framebuffer write port.
    logic        we_q, we_d;
    logic [9:0]  wx_q, wx_d;
    logic [8:0]  wy_q, wy_d;
    logic [3:0]  widx_q, widx_d;

    logic        last_px;
    logic [9:0]  base_x;
    logic [8:0]  base_y;
    logic [10:0] px;
    logic [9:0]  py;

    assign busy        = (state_q != StIdle) || done_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign we          = we_q;
    assign write_x     = wx_q;
    assign write_y     = wy_q;
    assign write_index = widx_q;
    assign sprite_addr = (state_q == StDraw) ?
                         AW'(13'(row_q) * 13'(SPR_W) + 13'(col_q)) : '0;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        drain_d      = drain_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        prev_valid_d = prev_valid_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        bg_d         = bg_q;
        last_px      = (col_q == 6'(SPR_W - 1)) && (row_q == 6'(SPR_H - 1));

        if (frame_start && busy) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_start && !done_q) begin
                    state_d = prev_valid_q ? StErase : StDraw;
                    new_x_d = sprite_x;
                    new_y_d = sprite_y;
                    bg_d    = bg_index;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StErase, StDraw: begin
                if (col_q == 6'(SPR_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + 6'd1;
                end else begin
                    col_d = col_q + 6'd1;
                end
                if (last_px) begin
                    row_d   = '0;
                    drain_d = 1'b0;
                    state_d = (state_q == StErase) ? StDraw : StDrain;
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d      = StIdle;
                    done_d       = 1'b1;
                    prev_valid_d = 1'b1;
                    prev_x_d     = new_x_q;
                    prev_y_d     = new_y_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        base_x     = (state_q == StErase) ? prev_x_q : new_x_q;
        base_y     = (state_q == StErase) ? prev_y_q : new_y_q;
        px         = {1'b0, base_x} + {5'b0, col_q};
        py         = {1'b0, base_y} + {4'b0, row_q};
        s1_valid_d = (state_q == StErase) || (state_q == StDraw);
        s1_draw_d  = (state_q == StDraw);
        s1_in_d    = (px < 11'd640) && (py < 10'd480);
        s1_x_d     = px[9:0];
        s1_y_d     = py[8:0];

        we_d   = s1_valid_q && s1_in_q &&
                 !(s1_draw_q && TranspEn && (sprite_index == TRANSP_IDX));
        widx_d = s1_draw_q ? sprite_index : bg_q;
        wx_d   = s1_x_q;
        wy_d   = s1_y_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            drain_q      <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            bg_q         <= '0;
            s1_valid_q   <= 1'b0;
            s1_draw_q    <= 1'b0;
            s1_in_q      <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            we_q         <= 1'b0;
            wx_q         <= '0;
            wy_q         <= '0;
            widx_q       <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            drain_q      <= drain_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            prev_valid_q <= prev_valid_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            bg_q         <= bg_d;
            s1_valid_q   <= s1_valid_d;
            s1_draw_q    <= s1_draw_d;
            s1_in_q      <= s1_in_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            we_q         <= we_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            widx_q       <= widx_d;
        end
    end

endmodule

// File: tb/tb_fb_blit_sequencer.sv
// Self-checking bench for fb_blit_sequencer (4x4 sprite) against a per-frame write-list model.
module tb_fb_blit_sequencer;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;
    localparam logic [3:0] TRANSP = 4'h0;
`ifdef BLIT_TRANSPARENCY_EN
    localparam bit TB_TRANSP = 1'b1;
`else
    localparam bit TB_TRANSP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] sprite_x = '0;
    logic [8:0] sprite_y = '0;
    logic [3:0] bg_index = '0;
    logic [3:0] sprite_addr;
    logic [3:0] sprite_index = '0;
    logic       we, busy, done, overrun;
    logic [9:0] write_x;
    logic [8:0] write_y;
    logic [3:0] write_index;

    logic [3:0] rom [16];

    typedef struct {
        int off;
        int x;
        int y;
        int idx;
    } wr_t;

    int vectors = 0;
    int miscompares = 0;
    bit prev_valid_m = 1'b0;
    int prev_x_m = 0;
    int prev_y_m = 0;
    bit ovr_m = 1'b0;

    fb_blit_sequencer #(
        .SPR_W      (W),
        .SPR_H      (H),
        .TRANSP_IDX (TRANSP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .bg_index     (bg_index),
        .sprite_addr  (sprite_addr),
        .sprite_index (sprite_index),
        .we           (we),
        .write_x      (write_x),
        .write_y      (write_y),
        .write_index  (write_index),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the address.
    always @(posedge clk) sprite_index <= rom[sprite_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a frame right after a negedge and checks every cycle up to one past done.
    // ovr_at: 0 = no extra pulse, -1 = pulse in the done cycle, >0 = pulse at that offset.
    task automatic run_frame(input int sx, input int sy, input int bg, input int ovr_at);
        wr_t q[$];
        wr_t e;
        int  base;
        int  done_off;
        int  ovr_t;
        bit  exp_we;
        if (prev_valid_m) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    e.off = 3 + r * W + c;
                    e.x   = prev_x_m + c;
                    e.y   = prev_y_m + r;
                    e.idx = bg;
                    if (e.x < 640 && e.y < 480) q.push_back(e);
                end
            end
        end
        base = prev_valid_m ? N : 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                e.off = 3 + base + r * W + c;
                e.x   = sx + c;
                e.y   = sy + r;
                e.idx = int'(rom[r * W + c]);
                if (e.x < 640 && e.y < 480 && !(TB_TRANSP && e.idx == int'(TRANSP)))
                    q.push_back(e);
            end
        end
        done_off = base + N + 3;
        ovr_t = (ovr_at < 0) ? done_off : ((ovr_at == 0) ? -100 : ovr_at);

        frame_start = 1'b1;
        sprite_x    = 10'(sx);
        sprite_y    = 9'(sy);
        bg_index    = 4'(bg);
        for (int t = 1; t <= done_off + 1; t++) begin
            @(negedge clk);
            if (t == ovr_t + 1) ovr_m = 1'b1;
            exp_we = (q.size() > 0) && (q[0].off == t);
            chk("we", 32'(we), 32'(exp_we));
            if (exp_we) begin
                chk("write_x", 32'(write_x), q[0].x);
                chk("write_y", 32'(write_y), q[0].y);
                chk("write_index", 32'(write_index), q[0].idx);
                q.delete(0);
            end
            chk("busy", 32'(busy), 32'(t <= done_off));
            chk("done", 32'(done), 32'(t == done_off));
            chk("overrun", 32'(overrun), 32'(ovr_m));
            chk("sprite_addr", 32'(sprite_addr),
                (t > base && t <= base + N) ? t - base - 1 : 0);
            if (t == 1) begin
                frame_start = 1'b0;
                sprite_x    = 10'($urandom);
                sprite_y    = 9'($urandom);
                bg_index    = 4'($urandom);
            end
            if (t == ovr_t) frame_start = 1'b1;
            else if (t == ovr_t + 1) frame_start = 1'b0;
        end
        chk("missing_writes", q.size(), 0);
        prev_valid_m = 1'b1;
        prev_x_m     = sx;
        prev_y_m     = sy;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_write_x"}, 32'(write_x), 0);
        chk({tag, "_write_y"}, 32'(write_y), 0);
        chk({tag, "_write_index"}, 32'(write_index), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_sprite_addr"}, 32'(sprite_addr), 0);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) rom[a] = 4'(a);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(10, 20, 0, 0);         // first frame: draw only
        run_frame(100, 50, 5, 0);        // erase old, draw new
        run_frame(638, 478, 3, 0);       // right/bottom clip
        run_frame(200, 100, 7, 10);      // frame_start while busy
        run_frame(300, 200, 2, -1);      // frame_start in the done cycle
        run_frame(50, 60, 1, 0);         // accepted in the cycle after done

        // Reset mid-DRAW of an erase+draw sequence.
        frame_start = 1'b1;
        sprite_x    = 10'd500;
        sprite_y    = 9'd400;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (N + 4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        @(negedge clk);
        reset_n      = 1'b1;
        prev_valid_m = 1'b0;
        ovr_m        = 1'b0;

        run_frame(400, 300, 9, 0);       // draw only after reset

        for (int i = 0; i < 8; i++) begin
            for (int a = 0; a < 16; a++) rom[a] = 4'($urandom);
            run_frame((i % 2 == 0) ? $urandom_range(0, 1023) : $urandom_range(630, 645),
                      (i % 2 == 0) ? $urandom_range(0, 511) : $urandom_range(470, 485),
                      $urandom_range(0, 15),
                      (i == 5) ? $urandom_range(1, 30) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
